// File: rtl/seven_seg_scan_n_if.sv
// Bus bundle for the N-digit hex display scanner.
//   master : drives the display data/controls and observes the pins
//            (register block or testbench)
//   slave  : the scanner itself
// Signals:
//   value       hex nibbles, digit i = value[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point request per digit (1 = lit)
//   digit_en    per-digit enable (0 = dark)
//   blank_lz    1 = blank leading zeros
//   brightness  PWM level, 0 = dimmest, max = full slot
//   blink_mask  1 = digit blinks
//   an          anodes, active-low
//   sseg        segments {g,f,e,d,c,b,a}, active-low
//   dp          decimal point, active-low
//   frame_start one-cycle pulse when slot 0 begins
interface seven_seg_scan_n_if #(
  parameter int NUM_DIGITS   = 4,
  parameter int BRIGHT_WIDTH = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic                    blank_lz;
  logic [BRIGHT_WIDTH-1:0] brightness;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              sseg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output value, dp_in, digit_en, blank_lz, brightness, blink_mask,
    input  an, sseg, dp, frame_start
  );

  modport slave (
    input  value, dp_in, digit_en, blank_lz, brightness, blink_mask,
    output an, sseg, dp, frame_start
  );
endinterface

// File: rtl/seven_seg_scan_n.sv
// N-digit time-multiplexed hex display scanner with built-in prescaler,
// hex-to-7-segment decode, per-digit enable, decimal points, leading-zero
// blanking, PWM brightness, per-digit blink and a per-frame input snapshot.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    seven_seg_scan_n_if.slave (data/controls in, an/sseg/dp/frame_start out)
module seven_seg_scan_n #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 100000,
  parameter int BRIGHT_WIDTH = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              reset,
  seven_seg_scan_n_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_DIGITS);
  localparam int PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0]       PWM_STEP  = 32'(PRESCALE / (2 ** BRIGHT_WIDTH));
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    case (nib)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Stage p0: scan timing, blink phase and the frame snapshot
  logic [PCNT_W-1:0]       pcnt_p0;
  logic [SLOT_W-1:0]       slot_p0;
  logic [FCNT_W-1:0]       fcnt_p0;
  logic                    phase_p0;
  logic [4*NUM_DIGITS-1:0] snap_value_p0;
  logic [NUM_DIGITS-1:0]   snap_dp_p0;
  logic [NUM_DIGITS-1:0]   snap_en_p0;
  logic [NUM_DIGITS-1:0]   snap_blink_p0;
  logic                    snap_blz_p0;
  logic [BRIGHT_WIDTH-1:0] snap_bright_p0;

  logic pcnt_wrap;
  logic frame_wrap;

  assign pcnt_wrap  = (pcnt_p0 == PCNT_LAST);
  assign frame_wrap = pcnt_wrap && (slot_p0 == SLOT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_p0        <= '0;
      slot_p0        <= '0;
      fcnt_p0        <= '0;
      phase_p0       <= 1'b0;
      snap_value_p0  <= '0;
      snap_dp_p0     <= '0;
      snap_en_p0     <= '0;
      snap_blink_p0  <= '0;
      snap_blz_p0    <= 1'b0;
      snap_bright_p0 <= '0;
    end else begin
      if (pcnt_wrap) begin
        pcnt_p0 <= '0;
        slot_p0 <= (slot_p0 == SLOT_LAST) ? '0 : slot_p0 + SLOT_W'(1);
      end else begin
        pcnt_p0 <= pcnt_p0 + PCNT_W'(1);
      end
      // The whole next frame is decided from this copy, so mid-frame input
      // changes cannot tear the displayed number.
      if (frame_wrap) begin
        snap_value_p0  <= bus.value;
        snap_dp_p0     <= bus.dp_in;
        snap_en_p0     <= bus.digit_en;
        snap_blink_p0  <= bus.blink_mask;
        snap_blz_p0    <= bus.blank_lz;
        snap_bright_p0 <= bus.brightness;
        if (fcnt_p0 == FCNT_LAST) begin
          fcnt_p0  <= '0;
          phase_p0 <= ~phase_p0;
        end else begin
          fcnt_p0 <= fcnt_p0 + FCNT_W'(1);
        end
      end
    end
  end

  // Leading-zero blanking walks from the most significant digit down; a digit
  // is blank while every nibble at or above it is zero. Digit 0 always shows.
  logic [NUM_DIGITS-1:0] blanked;
  logic                  all_zero;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  lit;
  logic [31:0]           on_time;
  logic                  pwm_on;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            sseg_nxt;
  logic                  dp_nxt;

  always_comb begin
    all_zero = 1'b1;
    blanked  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (snap_value_p0[4*i +: 4] == 4'h0);
      if (i != 0) blanked[i] = snap_blz_p0 & all_zero;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    lit     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_p0 == SLOT_W'(i)) begin
        cur_nib = snap_value_p0[4*i +: 4];
        cur_dp  = snap_dp_p0[i];
        lit     = snap_en_p0[i] & ~blanked[i] & ~(snap_blink_p0[i] & phase_p0);
      end
    end
  end

  // On-time grows in equal steps; brightness 0 still gives one step.
  assign on_time = (32'(snap_bright_p0) + 32'd1) * PWM_STEP;
  assign pwm_on  = (32'(pcnt_p0) < on_time);

  always_comb begin
    an_nxt = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (lit && pwm_on && (slot_p0 == SLOT_W'(i))) an_nxt[i] = 1'b0;
    end
    sseg_nxt = lit ? hex7(cur_nib) : 7'h7F;
    dp_nxt   = ~(cur_dp & lit);
  end

  // Stage p1: registered pins; an/sseg/dp switch together to avoid ghosting
  logic [NUM_DIGITS-1:0] an_p1;
  logic [6:0]            sseg_p1;
  logic                  dp_p1;
  logic                  frame_start_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_p1          <= '1;
      sseg_p1        <= 7'h7F;
      dp_p1          <= 1'b1;
      frame_start_p1 <= 1'b0;
    end else begin
      an_p1          <= an_nxt;
      sseg_p1        <= sseg_nxt;
      dp_p1          <= dp_nxt;
      frame_start_p1 <= frame_wrap;
    end
  end

  assign bus.an          = an_p1;
  assign bus.sseg        = sseg_p1;
  assign bus.dp          = dp_p1;
  assign bus.frame_start = frame_start_p1;
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Self-checking bench for seven_seg_scan_n with NUM_DIGITS=4, PRESCALE=16,
// BRIGHT_WIDTH=2, BLINK_FRAMES=2 (one frame = 64 clocks).
module tb_seven_seg_scan_n;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   frame_idx;

  typedef struct {
    logic [3:0] an;
    logic [6:0] sseg;
    logic       dp;
    int         lo;
  } exp_t;

  exp_t sbq[$];

  seven_seg_scan_n_if #(.NUM_DIGITS(4), .BRIGHT_WIDTH(2)) bus ();

  seven_seg_scan_n #(
    .NUM_DIGITS(4),
    .PRESCALE(16),
    .BRIGHT_WIDTH(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frames elapsed since reset release (number of slot-0 wraps seen).
  always @(negedge clk or negedge reset) begin
    if (!reset) frame_idx <= 0;
    else if (bus.frame_start) frame_idx <= frame_idx + 1;
  end

  // Samples one full 16-cycle slot starting at the current negedge; leaves the
  // bench at the first negedge of the following slot.
  task automatic observe_slot(output int lo, output logic [3:0] an_lo,
                              output logic [6:0] seg0, output logic dp0,
                              output int multi);
    lo    = 0;
    an_lo = 4'hF;
    multi = 0;
    seg0  = bus.sseg;
    dp0   = bus.dp;
    for (int k = 0; k < 16; k++) begin
      if (bus.an !== 4'hF) begin
        lo++;
        an_lo = bus.an;
        if ($countones(~bus.an) > 1) multi++;
      end
      @(negedge clk);
    end
  endtask

  // Waits for the next frame_start and steps to the first output cycle of slot 0.
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL frame_wait: no frame_start after %0d cycles, expected a pulse", n);
    end
    @(negedge clk);
  endtask

  task automatic set_inputs(input logic [15:0] v, input logic [3:0] en,
                            input logic [3:0] dpi, input logic [3:0] blk,
                            input logic blz, input logic [1:0] br);
    bus.value      = v;
    bus.digit_en   = en;
    bus.dp_in      = dpi;
    bus.blink_mask = blk;
    bus.blank_lz   = blz;
    bus.brightness = br;
  endtask

  task automatic test_reset();
    int n;
    int lit_cycles;
    reset = 1'b1;
    set_inputs(16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 2'd0);
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an !== 4'hF || bus.sseg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got an=%h sseg=%h dp=%b fs=%b, expected an=f sseg=7f dp=1 fs=0",
               bus.an, bus.sseg, bus.dp, bus.frame_start);
    end
    set_inputs(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
    #1 reset = 1'b1;
    n = 0;
    lit_cycles = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.an !== 4'hF) lit_cycles++;
      if (bus.frame_start === 1'b1) break;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL first_frame_len: got %0d cycles to frame_start, expected 64", n);
    end
    checks++;
    if (lit_cycles != 0) begin
      errors++;
      $display("FAIL first_frame_dark: got %0d lit cycles, expected 0", lit_cycles);
    end
    @(negedge clk);
  endtask

  task automatic test_scan();
    int lo, multi;
    logic [3:0] a;
    logic [6:0] s;
    logic d;
    exp_t e;
    sbq.push_back('{4'hE, 7'h19, 1'b1, 16});
    sbq.push_back('{4'hD, 7'h30, 1'b1, 16});
    sbq.push_back('{4'hB, 7'h24, 1'b1, 16});
    sbq.push_back('{4'h7, 7'h79, 1'b1, 16});
    for (int sl = 0; sl < 4; sl++) begin
      observe_slot(lo, a, s, d, multi);
      e = sbq.pop_front();
      checks++;
      if (a !== e.an || s !== e.sseg || d !== e.dp || lo != e.lo) begin
        errors++;
        $display("FAIL scan slot%0d: got an=%h sseg=%h dp=%b lo=%0d, expected an=%h sseg=%h dp=%b lo=%0d",
                 sl, a, s, d, lo, e.an, e.sseg, e.dp, e.lo);
      end
      checks++;
      if (multi != 0) begin
        errors++;
        $display("FAIL scan_onehot slot%0d: got %0d multi-anode cycles, expected 0", sl, multi);
      end
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    int lo, multi;
    logic [3:0] a;
    logic [6:0] s;
    logic d;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.an !== 4'hE) begin
      errors++;
      $display("FAIL midrun_pre: got an=%h, expected e", bus.an);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.an !== 4'hF || bus.sseg !== 7'h7F || bus.dp !== 1'b1 || bus.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL midrun_async: got an=%h sseg=%h dp=%b fs=%b, expected an=f sseg=7f dp=1 fs=0",
               bus.an, bus.sseg, bus.dp, bus.frame_start);
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.frame_start === 1'b1) break;
    end
    checks++;
    if (n != 64) begin
      errors++;
      $display("FAIL midrun_restart: got %0d cycles to frame_start, expected 64", n);
    end
    @(negedge clk);
    observe_slot(lo, a, s, d, multi);
    checks++;
    if (a !== 4'hE || s !== 7'h19 || lo != 16) begin
      errors++;
      $display("FAIL midrun_resume: got an=%h sseg=%h lo=%0d, expected an=e sseg=19 lo=16", a, s, lo);
    end
  endtask

  task automatic test_leading_zeros();
    int lo, multi;
    logic [3:0] a;
    logic [6:0] s;
    logic d;
    exp_t e;
    set_inputs(16'h0050, 4'hF, 4'h0, 4'h0, 1'b1, 2'd3);
    wait_frame();
    sbq.push_back('{4'hE, 7'h40, 1'b1, 16});
    sbq.push_back('{4'hD, 7'h12, 1'b1, 16});
    sbq.push_back('{4'hF, 7'h7F, 1'b1, 0});
    sbq.push_back('{4'hF, 7'h7F, 1'b1, 0});
    for (int sl = 0; sl < 4; sl++) begin
      observe_slot(lo, a, s, d, multi);
      e = sbq.pop_front();
      checks++;
      if (a !== e.an || s !== e.sseg || d !== e.dp || lo != e.lo) begin
        errors++;
        $display("FAIL lz_0050 slot%0d: got an=%h sseg=%h dp=%b lo=%0d, expected an=%h sseg=%h dp=%b lo=%0d",
                 sl, a, s, d, lo, e.an, e.sseg, e.dp, e.lo);
      end
    end
    bus.value = 16'h0000;
    wait_frame();
    sbq.push_back('{4'hE, 7'h40, 1'b1, 16});
    sbq.push_back('{4'hF, 7'h7F, 1'b1, 0});
    sbq.push_back('{4'hF, 7'h7F, 1'b1, 0});
    sbq.push_back('{4'hF, 7'h7F, 1'b1, 0});
    for (int sl = 0; sl < 4; sl++) begin
      observe_slot(lo, a, s, d, multi);
      e = sbq.pop_front();
      checks++;
      if (a !== e.an || s !== e.sseg || d !== e.dp || lo != e.lo) begin
        errors++;
        $display("FAIL lz_0000 slot%0d: got an=%h sseg=%h dp=%b lo=%0d, expected an=%h sseg=%h dp=%b lo=%0d",
                 sl, a, s, d, lo, e.an, e.sseg, e.dp, e.lo);
      end
    end
  endtask

  task automatic test_brightness();
    int lo, multi;
    logic [3:0] a;
    logic [6:0] s;
    logic d;
    logic [1:0] levels [3];
    int on_cycles [3];
    exp_t e;
    levels[0] = 2'd0; on_cycles[0] = 4;
    levels[1] = 2'd2; on_cycles[1] = 12;
    levels[2] = 2'd3; on_cycles[2] = 16;
    for (int b = 0; b < 3; b++) begin
      set_inputs(16'h1234, 4'hF, 4'h0, 4'h0, 1'b0, levels[b]);
      wait_frame();
      sbq.push_back('{4'hE, 7'h19, 1'b1, on_cycles[b]});
      observe_slot(lo, a, s, d, multi);
      e = sbq.pop_front();
      checks++;
      if (a !== e.an || s !== e.sseg || lo != e.lo) begin
        errors++;
        $display("FAIL bright_%0d: got an=%h sseg=%h lo=%0d, expected an=%h sseg=%h lo=%0d",
                 levels[b], a, s, lo, e.an, e.sseg, e.lo);
      end
    end
  endtask

  task automatic test_snapshot();
    int lo, multi, fs_cnt;
    logic [3:0] a;
    logic [6:0] s;
    logic d;
    exp_t e;
    logic [3:0] an_order [4];
    an_order[0] = 4'hE; an_order[1] = 4'hD; an_order[2] = 4'hB; an_order[3] = 4'h7;
    set_inputs(16'h1111, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
    wait_frame();
    for (int sl = 0; sl < 4; sl++) sbq.push_back('{an_order[sl], 7'h79, 1'b1, 16});
    for (int sl = 0; sl < 8; sl++) begin
      if (sl == 2) bus.value = 16'h2222;
      if (sl == 4) begin
        for (int k = 0; k < 4; k++) sbq.push_back('{an_order[k], 7'h24, 1'b1, 16});
      end
      observe_slot(lo, a, s, d, multi);
      e = sbq.pop_front();
      checks++;
      if (a !== e.an || s !== e.sseg || d !== e.dp || lo != e.lo) begin
        errors++;
        $display("FAIL snapshot slot%0d: got an=%h sseg=%h dp=%b lo=%0d, expected an=%h sseg=%h dp=%b lo=%0d",
                 sl, a, s, d, lo, e.an, e.sseg, e.dp, e.lo);
      end
    end
    for (int w = 0; w < 2; w++) begin
      fs_cnt = 0;
      for (int k = 0; k < 64; k++) begin
        if (bus.frame_start === 1'b1) fs_cnt++;
        @(negedge clk);
      end
      checks++;
      if (fs_cnt != 1) begin
        errors++;
        $display("FAIL frame_start_rate win%0d: got %0d pulses in 64 cycles, expected 1", w, fs_cnt);
      end
    end
  endtask

  task automatic test_blink_dp_en();
    int lo, multi, ph;
    logic [3:0] a;
    logic [6:0] s;
    logic d;
    exp_t e;
    set_inputs(16'h1234, 4'b1011, 4'b0010, 4'b0001, 1'b0, 2'd3);
    wait_frame();
    for (int f = 0; f < 6; f++) begin
      ph = (frame_idx / 2) % 2;
      if (ph == 0) sbq.push_back('{4'hE, 7'h19, 1'b1, 16});
      else         sbq.push_back('{4'hF, 7'h7F, 1'b1, 0});
      sbq.push_back('{4'hD, 7'h30, 1'b0, 16});
      sbq.push_back('{4'hF, 7'h7F, 1'b1, 0});
      sbq.push_back('{4'h7, 7'h79, 1'b1, 16});
      for (int sl = 0; sl < 4; sl++) begin
        observe_slot(lo, a, s, d, multi);
        e = sbq.pop_front();
        checks++;
        if (a !== e.an || s !== e.sseg || d !== e.dp || lo != e.lo) begin
          errors++;
          $display("FAIL blink frame%0d slot%0d: got an=%h sseg=%h dp=%b lo=%0d, expected an=%h sseg=%h dp=%b lo=%0d",
                   f, sl, a, s, d, lo, e.an, e.sseg, e.dp, e.lo);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_scan();
    test_reset_midrun();
    test_leading_zeros();
    test_brightness();
    test_snapshot();
    test_blink_dp_en();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
